shift_unit_seq: RTL

- Multicycle shifter that consumes the 5-bit shift amount chosen by the shift-amount select path (shamt field, reg B[4:0] or mem[4:0]).
- Accepts one operand and one operation on a start pulse, then shifts one bit position per clock.
- Signals completion with a one-cycle done pulse.
- Sits in the datapath between the shift-amount/operand muxes and the write-back mux; sequenced by the control unit.

---
 rtl/shift_unit_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multicycle shifter, one bit position per clock, with a one-cycle done pulse.
// Revision: 1.0
`default_nettype none

module shift_unit_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         shift_op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [SHAMT_W-1:0] count;
  logic [2:0]         op_lat;
  logic [WIDTH-1:0]   shifted;
  logic               start_is_trivial;

  // Zero amount or an unassigned opcode skips SHIFT, so count never underflows.
  assign start_is_trivial = (shamt == CNT_ZERO) || (shift_op > OP_ROL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = start_is_trivial ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (count == CNT_ONE) begin
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_comb begin
    shifted = data_out;
    case (op_lat)
      OP_SLL:  shifted = {data_out[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, data_out[WIDTH-1:1]};
      OP_SRA:  shifted = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
      OP_ROR:  shifted = {data_out[0], data_out[WIDTH-1:1]};
      OP_ROL:  shifted = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
      default: shifted = data_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      count    <= '0;
      op_lat   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            data_out <= data_in;
            count    <= shamt;
            op_lat   <= shift_op;
          end
        end
        S_SHIFT: begin
          data_out <= shifted;
          count    <= count - CNT_ONE;
        end
        default: begin
          data_out <= data_out;
          count    <= count;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
